// File: rtl/t08_load_store_unit.sv
// Load/store unit: decodes RISC-V style memory ops, drives a simple
// req/ack word bus, extracts/extends load data and flags faults.
module t08_load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [5:0]  alu_control,
    input  logic        mem_valid,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        misaligned,
    output logic        bus_error
);

    localparam logic [5:0] OP_LB  = 6'd20;
    localparam logic [5:0] OP_LH  = 6'd21;
    localparam logic [5:0] OP_LW  = 6'd22;
    localparam logic [5:0] OP_LBU = 6'd23;
    localparam logic [5:0] OP_LHU = 6'd24;
    localparam logic [5:0] OP_SB  = 6'd25;
    localparam logic [5:0] OP_SH  = 6'd26;
    localparam logic [5:0] OP_SW  = 6'd27;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [5:0]  op_q;
    logic [1:0]  lo_q;

    logic        valid_op;
    logic        is_store;
    logic        sz_b;
    logic        sz_h;
    logic        sz_w;
    logic        mis_n;
    logic [3:0]  sel_n;
    logic [31:0] wdata_n;
    logic        accept;

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext_v;

    // Decode the incoming request: access size, direction, lanes, data.
    always_comb begin
        valid_op = 1'b0;
        is_store = 1'b0;
        sz_b     = 1'b0;
        sz_h     = 1'b0;
        sz_w     = 1'b0;
        unique case (alu_control)
            OP_LB, OP_LBU: begin
                valid_op = 1'b1;
                sz_b     = 1'b1;
            end
            OP_LH, OP_LHU: begin
                valid_op = 1'b1;
                sz_h     = 1'b1;
            end
            OP_LW: begin
                valid_op = 1'b1;
                sz_w     = 1'b1;
            end
            OP_SB: begin
                valid_op = 1'b1;
                is_store = 1'b1;
                sz_b     = 1'b1;
            end
            OP_SH: begin
                valid_op = 1'b1;
                is_store = 1'b1;
                sz_h     = 1'b1;
            end
            OP_SW: begin
                valid_op = 1'b1;
                is_store = 1'b1;
                sz_w     = 1'b1;
            end
            default: ;
        endcase

        mis_n = (sz_h & address[0]) | (sz_w & (address[1:0] != 2'b00));

        sel_n   = 4'b0000;
        wdata_n = 32'h0;
        if (sz_b) sel_n = 4'b0001 << address[1:0];
        if (sz_h) sel_n = address[1] ? 4'b1100 : 4'b0011;
        if (sz_w) sel_n = 4'b1111;
        if (is_store) begin
            if (sz_b) wdata_n = {4{store_data[7:0]}};
            if (sz_h) wdata_n = {2{store_data[15:0]}};
            if (sz_w) wdata_n = store_data;
        end
    end

    // A request is taken only from IDLE; illegal opcodes are ignored.
    always_comb begin
        accept = nRst & (state == IDLE) & mem_valid & valid_op;
        stall  = (state == ACCESS) | accept;
    end

    // Pick the addressed lane of the returned word and extend it.
    always_comb begin
        byte_v = bus_rdata[{lo_q, 3'b000} +: 8];
        half_v = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ext_v  = 32'h0;
        unique case (op_q)
            OP_LB:   ext_v = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  ext_v = {24'h0, byte_v};
            OP_LH:   ext_v = {{16{half_v[15]}}, half_v};
            OP_LHU:  ext_v = {16'h0, half_v};
            OP_LW:   ext_v = bus_rdata;
            default: ext_v = 32'h0;
        endcase
    end

    // Control FSM with registered bus and status outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            op_q       <= 6'd0;
            lo_q       <= 2'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_sel    <= 4'b0000;
            load_data  <= 32'h0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= alu_control;
                        lo_q <= address[1:0];
                        cnt  <= 8'd0;
                        if (mis_n) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                            load_data  <= 32'h0;
                        end else begin
                            state     <= ACCESS;
                            bus_req   <= 1'b1;
                            bus_we    <= is_store;
                            bus_addr  <= {address[31:2], 2'b00};
                            bus_sel   <= sel_n;
                            bus_wdata <= wdata_n;
                        end
                    end
                end
                ACCESS: begin
                    if (bus_ack || cnt == LAST) begin
                        state     <= DONE;
                        cnt       <= 8'd0;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= 32'h0;
                        bus_sel   <= 4'b0000;
                        bus_wdata <= 32'h0;
                        done      <= 1'b1;
                        if (bus_ack) begin
                            if (op_q < OP_SB) load_data <= ext_v;
                        end else begin
                            bus_error <= 1'b1;
                            load_data <= 32'h0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t08_load_store_unit.sv
// Scoreboard bench for t08_load_store_unit: random and directed memory
// ops against an arithmetic reference model.
module tb_t08_load_store_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        nRst;
    logic [5:0]  alu_control;
    logic        mem_valid;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] load_data;
    logic        stall;
    logic        done;
    logic        misaligned;
    logic        bus_error;

    t08_load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .alu_control(alu_control),
        .mem_valid  (mem_valid),
        .address    (address),
        .store_data (store_data),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_sel    (bus_sel),
        .load_data  (load_data),
        .stall      (stall),
        .done       (done),
        .misaligned (misaligned),
        .bus_error  (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic        err;
        logic        chk_ld;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] ld;
        logic [31:0] wdata;
        logic [31:0] baddr;
        int          reqs;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   reqs_seen = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req,
                     $time);
        end
    endtask

    // Reference: sizes, lanes and extension from plain arithmetic.
    function automatic exp_t model(input int op, input logic [31:0] a,
                                   input logic [31:0] sd,
                                   input logic [31:0] rd, input int lat);
        exp_t        e;
        int          size;
        int          off;
        bit          st;
        bit          sgn;
        logic [31:0] mask;
        logic [31:0] v;
        size = (op == 20 || op == 23 || op == 25) ? 1 :
               (op == 21 || op == 24 || op == 26) ? 2 : 4;
        st   = (op >= 25);
        sgn  = (op == 20 || op == 21);
        off  = int'(a % 4);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
        e.mis   = ((a % size) != 0);
        e.err   = !e.mis && (lat >= TMO);
        e.baddr = a - off;
        e.we    = st;
        e.sel   = 4'(((1 << size) - 1) << off);
        if (!st) e.wdata = 32'h0;
        else if (size == 4) e.wdata = sd;
        else e.wdata = (sd & mask) *
                       ((size == 1) ? 32'h0101_0101 : 32'h0001_0001);
        v = (rd >> (8 * off)) & mask;
        if (sgn && v[8 * size - 1]) v = v | ~mask;
        e.ld     = (e.mis || e.err) ? 32'h0 : v;
        e.chk_ld = !st || e.mis || e.err;
        e.reqs   = e.mis ? 0 : (e.err ? TMO : lat + 1);
        return e;
    endfunction

    // Issue one op and play the bus slave; lat>=TMO means never ack.
    task automatic run_op(input int op, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int lat);
        exp_t e;
        int   cyc;
        bit   got;
        int   k;
        e = model(op, a, sd, rd, lat);
        exp_q.push_back(e);
        @(posedge clk); #2;
        alu_control = 6'(op);
        address     = a;
        store_data  = sd;
        mem_valid   = 1'b1;
        bus_ack     = 1'b0;
        cyc = 0;
        got = 0;
        k   = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk); #2;
            bus_ack = 1'b0;
            if (done) begin
                got       = 1;
                k         = i;
                mem_valid = 1'b0;
            end else if (bus_req) begin
                if (cyc == lat) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rd;
                end else begin
                    bus_rdata = $urandom;
                end
                cyc++;
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout actual=none required=done op=%0d", op);
            mem_valid = 1'b0;
        end else begin
            chk("latency", 32'(k), 32'(e.reqs));
        end
    endtask

    // Monitor: compares every presented bus cycle and completion.
    always @(negedge clk) begin
        exp_t e;
        logic es;
        if (!nRst) begin
            chk("rst_req", 32'(bus_req), 32'd0);
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_ld", load_data, 32'h0);
            reqs_seen = 0;
        end else begin
            es = (mem_valid && alu_control >= 6'd20 && alu_control <= 6'd27)
                 || bus_req;
            chk("stall", 32'(stall), 32'(es));
            if (!done) begin
                chk("mis_idle", 32'(misaligned), 32'd0);
                chk("err_idle", 32'(bus_error), 32'd0);
            end
            if (bus_req) begin
                reqs_seen++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_req actual=1 required=0");
                end else begin
                    e = exp_q[0];
                    chk("bus_addr", bus_addr, e.baddr);
                    chk("bus_we", 32'(bus_we), 32'(e.we));
                    chk("bus_sel", 32'(bus_sel), 32'(e.sel));
                    chk("bus_wdata", bus_wdata, e.wdata);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("misaligned", 32'(misaligned), 32'(e.mis));
                    chk("bus_error", 32'(bus_error), 32'(e.err));
                    chk("req_cycles", 32'(reqs_seen), 32'(e.reqs));
                    if (e.chk_ld) chk("load_data", load_data, e.ld);
                end
                reqs_seen = 0;
            end
        end
    end

    initial begin
        int          op;
        logic [31:0] a;
        int          lat;
        nRst        = 1'b0;
        alu_control = 6'd0;
        mem_valid   = 1'b0;
        address     = 32'h0;
        store_data  = 32'h0;
        bus_rdata   = 32'h0;
        bus_ack     = 1'b0;
        repeat (3) @(posedge clk);
        #2 nRst = 1'b1;

        run_op(20, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
        run_op(26, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3);
        run_op(22, 32'h0000_0001, 32'h0, 32'h1234_5678, 0);
        run_op(24, 32'h0000_0010, 32'h0, 32'hFFFF_FFFF, TMO);

        // Abort a store mid-access with reset, then a plain load.
        exp_q.push_back(model(27, 32'h0000_3000, 32'hDEAD_BEEF, 0, TMO));
        @(posedge clk); #2;
        alu_control = 6'd27;
        address     = 32'h0000_3000;
        store_data  = 32'hDEAD_BEEF;
        mem_valid   = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        nRst      = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("async_req", 32'(bus_req), 32'd0);
        chk("async_stall", 32'(stall), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        exp_q.delete();
        @(posedge clk); #2 nRst = 1'b1;
        run_op(23, 32'h0000_0001, 32'h0, 32'h0000_9A00, 0);

        // Non-memory opcode must be ignored entirely.
        @(posedge clk); #2;
        alu_control = 6'd1;
        mem_valid   = 1'b1;
        repeat (10) @(posedge clk);
        #2 mem_valid = 1'b0;

        for (int n = 0; n < 150; n++) begin
            op  = 20 + int'($urandom_range(0, 7));
            a   = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            lat = ($urandom_range(0, 9) == 0) ? TMO
                                              : int'($urandom_range(0, 4));
            run_op(op, a, $urandom, $urandom, lat);
        end

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
